// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//
// Shared definitions for the stopwatch control sequencer and its bench:
//   - state_e    : 2-bit sequencer state encoding (IDLE/RUN/PAUSE/LAP)
//   - BTN_*      : bit positions of the buttons within the 4-bit button bus
//   - is_running : true for the states in which the counter is enabled
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  localparam int NUM_BTN   = 4;
  localparam int BTN_START = 3;
  localparam int BTN_LAP   = 2;
  localparam int BTN_CLEAR = 1;
  localparam int BTN_RSVD  = 0;

  // The counter keeps running in LAP; only the display is frozen.
  function automatic logic is_running(input logic [1:0] st);
    return (st == RUN) || (st == LAP);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions one raw active-low push button into a single-cycle press pulse.
//   2-flop synchronizer -> stability counter -> falling-edge detector
//
// The debounced level only follows the synchronized input after
// DEBOUNCE_CYCLES consecutive samples that differ from the current level.
// A press (debounced 1 -> 0) gives exactly one pulse; releases give nothing.
// Raw edge to press_o high: 2 + DEBOUNCE_CYCLES + 1 clock cycles.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (all levels reset to released)
//   button_i in   raw button, active-low (1 = released)
//   press_o  out  one-cycle press pulse, registered
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_deb_check
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic             level_p3;
  logic [CNT_W-1:0] stable_cnt;

  // ---- stage 0/1: two-flop synchronizer, released level out of reset ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= button_i;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage 2: debounced level ----
  // The counter tracks how many consecutive samples disagreed with the
  // accepted level; any agreeing sample restarts the count, so glitches
  // shorter than DEBOUNCE_CYCLES never reach level_p2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_p2   <= 1'b1;
      stable_cnt <= '0;
    end else if (sync_p1 == level_p2) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      level_p2   <= sync_p1;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  // ---- stage 3: falling-edge detect, registered pulse ----
  // Levels reset to released, so a button held through reset release still
  // produces one press once it has been debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_p3 <= 1'b1;
      press_o  <= 1'b0;
    end else begin
      level_p3 <= level_p2;
      press_o  <= level_p3 & ~level_p2;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control sequencer for the stopwatch counter datapath: conditions the
// start/pause, lap and clear buttons, runs the IDLE/RUN/PAUSE/LAP state
// machine and generates the count tick while running.
//
// Parameters
//   CLK_HZ          system clock frequency
//   TICK_HZ         tick_o rate while running; CLK_HZ/TICK_HZ must be >= 2
//   DEBOUNCE_CYCLES stable synchronized cycles needed to accept a level
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   button_i  in   [3] start/pause, [2] lap, [1] clear, [0] reserved; active-low
//   tick_o    out  one-cycle pulse per 1/TICK_HZ s of running time
//   clear_o   out  one-cycle counter clear pulse
//   run_o     out  counter enable, high in RUN and LAP
//   freeze_o  out  display hold, high in LAP
//   state_o   out  current state (stopwatch_pkg::state_e encoding)
// All outputs are registered.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] button_i,
  output logic               tick_o,
  output logic               clear_o,
  output logic               run_o,
  output logic               freeze_o,
  output logic [1:0]         state_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_LAP   = LAP;

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be >= 2");
  end

  logic             start_evt;
  logic             lap_evt;
  logic             clear_evt;
  logic             btn_rsvd_unused;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic             clear_nxt;
  logic             run_nxt;
  logic             tick_nxt;
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_nxt;

  assign btn_rsvd_unused = button_i[BTN_RSVD];

  // ---- button conditioning: one press pulse per button ----
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i[BTN_START]),
    .press_o  (start_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i[BTN_LAP]),
    .press_o  (lap_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i[BTN_CLEAR]),
    .press_o  (clear_evt)
  );

  // ---- next state: clear beats start beats lap; lower events are dropped ----
  always_comb begin
    state_nxt = state_q;
    clear_nxt = 1'b0;
    if (clear_evt) begin
      state_nxt = S_IDLE;
      clear_nxt = 1'b1;
    end else if (start_evt) begin
      case (state_q)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   state_nxt = S_PAUSE;
        S_PAUSE: state_nxt = S_RUN;
        S_LAP:   state_nxt = S_PAUSE;
        default: state_nxt = S_IDLE;
      endcase
    end else if (lap_evt) begin
      case (state_q)
        S_RUN:   state_nxt = S_LAP;
        S_LAP:   state_nxt = S_RUN;
        default: state_nxt = state_q;
      endcase
    end
  end

  // Prescaler advances on cycles where run_o is already high and holds in
  // PAUSE so a resume finishes the interrupted period. The tick is computed
  // from the next count so tick_o is high in exactly the cycle whose count
  // is DIV-1, and never once run_o has dropped.
  always_comb begin
    if (clear_nxt || (state_nxt == S_IDLE)) begin
      presc_nxt = '0;
    end else if (run_o) begin
      presc_nxt = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    end else begin
      presc_nxt = presc_q;
    end
    run_nxt  = is_running(state_nxt);
    tick_nxt = run_nxt && (presc_nxt == PRE_LAST);
  end

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      tick_o   <= 1'b0;
      clear_o  <= 1'b0;
      run_o    <= 1'b0;
      freeze_o <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      presc_q  <= presc_nxt;
      tick_o   <= tick_nxt;
      clear_o  <= clear_nxt;
      run_o    <= run_nxt;
      freeze_o <= (state_nxt == S_LAP);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with CLK_HZ=100, TICK_HZ=10 (DIV=10),
// DEBOUNCE_CYCLES=4. Hand sequences cover reset, start latency and tick
// spacing, glitch rejection, pause/resume, priority and reset mid-run; a
// vector table walks the state machine through its transitions.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DEB     = 4;
  localparam int DIV     = 10;

  localparam logic [3:0] M_START = 4'(1) << BTN_START;
  localparam logic [3:0] M_LAP   = 4'(1) << BTN_LAP;
  localparam logic [3:0] M_CLEAR = 4'(1) << BTN_CLEAR;

  typedef struct {
    logic [3:0] mask;   // buttons pressed together
    logic [1:0] st;     // expected state after settling
    logic       run;
    logic       frz;
    int         clrs;   // expected clear_o pulses during the press
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] button_i = 4'hF;
  logic       tick_o;
  logic       clear_o;
  logic       run_o;
  logic       freeze_o;
  logic [1:0] state_o;

  int n_vec    = 0;
  int n_err    = 0;
  int ph       = 0;
  int clr_cnt  = 0;
  int tick_cnt = 0;

  vec_t vecs [20];

  stopwatch_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i),
    .tick_o   (tick_o),
    .clear_o  (clear_o),
    .run_o    (run_o),
    .freeze_o (freeze_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and sample. ph counts running cycles
  // within the current tick period: the tick belongs to the DIV-th running
  // cycle of each period, and leaving for IDLE restarts the period.
  task automatic step();
    @(negedge clk);
    if (clear_o) clr_cnt++;
    if (tick_o)  tick_cnt++;
    if (!rst_n || state_o == IDLE) ph = 0;
    if (run_o) begin
      check("tick_period", int'(tick_o), int'(ph == DIV - 1));
      ph = (ph + 1) % DIV;
    end else begin
      check("tick_not_running", int'(tick_o), 0);
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int settle);
    button_i = ~mask;
    repeat (hold) step();
    button_i = 4'hF;
    repeat (settle) step();
  endtask

  task automatic wait_tick(input string name);
    int found;
    found = 0;
    for (int i = 0; i < DIV + 2 && found == 0; i++) begin
      step();
      if (tick_o) found = 1;
    end
    check(name, found, 1);
  endtask

  initial begin
    int rc;
    int t0;
    int c0;
    int first;

    vecs[0]  = '{M_LAP,           LAP,   1'b1, 1'b1, 0};
    vecs[1]  = '{M_LAP,           RUN,   1'b1, 1'b0, 0};
    vecs[2]  = '{M_LAP,           LAP,   1'b1, 1'b1, 0};
    vecs[3]  = '{M_START,         PAUSE, 1'b0, 1'b0, 0};
    vecs[4]  = '{M_LAP,           PAUSE, 1'b0, 1'b0, 0};
    vecs[5]  = '{M_START,         RUN,   1'b1, 1'b0, 0};
    vecs[6]  = '{M_CLEAR,         IDLE,  1'b0, 1'b0, 1};
    vecs[7]  = '{M_LAP,           IDLE,  1'b0, 1'b0, 0};
    vecs[8]  = '{M_CLEAR,         IDLE,  1'b0, 1'b0, 1};
    vecs[9]  = '{M_START,         RUN,   1'b1, 1'b0, 0};
    vecs[10] = '{M_START | M_LAP, PAUSE, 1'b0, 1'b0, 0};
    vecs[11] = '{M_START,         RUN,   1'b1, 1'b0, 0};
    vecs[12] = '{M_LAP,           LAP,   1'b1, 1'b1, 0};
    vecs[13] = '{M_LAP | M_CLEAR, IDLE,  1'b0, 1'b0, 1};
    vecs[14] = '{M_START,         RUN,   1'b1, 1'b0, 0};
    vecs[15] = '{M_START | M_LAP, PAUSE, 1'b0, 1'b0, 0};
    vecs[16] = '{M_START,         RUN,   1'b1, 1'b0, 0};
    vecs[17] = '{M_LAP,           LAP,   1'b1, 1'b1, 0};
    vecs[18] = '{M_START | M_LAP, PAUSE, 1'b0, 1'b0, 0};
    vecs[19] = '{M_START,         RUN,   1'b1, 1'b0, 0};

    // Reset: held three cycles, outputs quiet during and after.
    #1 rst_n = 1'b0;
    repeat (3) begin
      step();
      check("reset_held_outputs", int'({tick_o, clear_o, run_o, freeze_o, state_o}), 0);
    end
    rst_n = 1'b1;
    repeat (2) step();
    check("reset_release_outputs", int'({tick_o, clear_o, run_o, freeze_o, state_o}), 0);

    // Glitch: two cycles low never reaches the debounced level.
    clr_cnt = 0; tick_cnt = 0;
    button_i[BTN_START] = 1'b0;
    repeat (2) step();
    button_i[BTN_START] = 1'b1;
    repeat (20) step();
    check("glitch_state", int'(state_o), int'(IDLE));
    check("glitch_run", int'(run_o), 0);
    check("glitch_ticks", tick_cnt, 0);

    // Start: 8 cycles raw edge to RUN, ticks on running cycles 10/20/30.
    rc = 0;
    t0 = tick_cnt;
    button_i[BTN_START] = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      step();
      if (c == 12) button_i[BTN_START] = 1'b1;
      if (c == 7) check("start_latency_before", int'(state_o), int'(IDLE));
      if (c == 8) begin
        check("start_latency_state", int'(state_o), int'(RUN));
        check("start_latency_run", int'(run_o), 1);
      end
      if (run_o) begin
        rc++;
        check("start_tick_cycle", int'(tick_o), int'((rc % 10) == 0));
      end
    end
    check("start_single_press", int'(state_o), int'(RUN));
    check("start_tick_count", tick_cnt - t0, 3);
    check("start_no_clear", clr_cnt, 0);

    // Pause 7 running cycles after a tick, hold 50 cycles, resume.
    wait_tick("pause_align_tick");
    button_i[BTN_START] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c <= 7) begin
        check("pause_still_running", int'(run_o), 1);
        check("pause_early_tick", int'(tick_o), 0);
      end
    end
    button_i[BTN_START] = 1'b1;
    check("pause_state", int'(state_o), int'(PAUSE));
    check("pause_run", int'(run_o), 0);
    t0 = tick_cnt;
    repeat (50) step();
    check("pause_no_ticks", tick_cnt - t0, 0);
    check("pause_held", int'(state_o), int'(PAUSE));
    button_i[BTN_START] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 8) button_i[BTN_START] = 1'b1;
      if (c == 7)  check("resume_before", int'(run_o), 0);
      if (c == 8)  check("resume_run", int'(run_o), 1);
      if (c == 8)  check("resume_tick_1st", int'(tick_o), 0);
      if (c == 9)  check("resume_tick_2nd", int'(tick_o), 0);
      if (c == 10) check("resume_tick_3rd", int'(tick_o), 1);
    end
    repeat (10) step();

    // Transition table, starting from RUN.
    foreach (vecs[i]) begin
      c0 = clr_cnt;
      press(vecs[i].mask, 8, 10);
      check($sformatf("vec%0d_state", i), int'(state_o), int'(vecs[i].st));
      check($sformatf("vec%0d_run", i), int'(run_o), int'(vecs[i].run));
      check($sformatf("vec%0d_freeze", i), int'(freeze_o), int'(vecs[i].frz));
      check($sformatf("vec%0d_clears", i), clr_cnt - c0, vecs[i].clrs);
    end

    // Priority: start and clear together in RUN, part way into a period.
    wait_tick("prio_align_tick");
    repeat (3) step();
    c0 = clr_cnt;
    press(M_START | M_CLEAR, 8, 10);
    check("prio_clear_pulses", clr_cnt - c0, 1);
    check("prio_state", int'(state_o), int'(IDLE));
    check("prio_run", int'(run_o), 0);
    t0 = tick_cnt;
    repeat (30) step();
    check("prio_no_ticks", tick_cnt - t0, 0);
    // Prescaler was zeroed: the first tick is the 10th running cycle.
    rc = 0;
    first = -1;
    button_i[BTN_START] = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 8) button_i[BTN_START] = 1'b1;
      if (run_o) rc++;
      if (tick_o && first < 0) first = rc;
    end
    check("prio_prescaler_zero", first, 10);

    // Reset mid-RUN acts without a clock edge; a button held through
    // release gives exactly one press.
    step();
    check("midrst_before_run", int'(run_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_run", int'(run_o), 0);
    check("midrst_async_state", int'(state_o), int'(IDLE));
    check("midrst_async_freeze", int'(freeze_o), 0);
    c0 = clr_cnt;
    button_i[BTN_START] = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      step();
      if (c == 7) check("held_reset_before", int'(state_o), int'(IDLE));
      if (c == 8) check("held_reset_press", int'(state_o), int'(RUN));
    end
    button_i[BTN_START] = 1'b1;
    repeat (10) step();
    check("held_reset_single", int'(state_o), int'(RUN));
    check("midrst_no_clear", clr_cnt - c0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch counter datapath. It conditions the four raw active-low push buttons, runs the start/pause/lap/clear state machine, and generates the millisecond tick enable. It drives the counter's clear, count-enable and display-freeze inputs, so the counter and seven-segment logic hold no button handling of their own.

## Interface
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 1000, tick_o rate while running; DIV = CLK_HZ/TICK_HZ, must be ≥ 2 (elaboration error otherwise).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new button level (≥ 1).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- button_i  in  4  raw buttons, active-low (1 = released); [3] start/pause, [2] lap, [1] clear, [0] reserved/ignored.
- tick_o  out  1  one-cycle pulse per 1/TICK_HZ s of running time.
- clear_o  out  1  one-cycle pulse; counter clears to zero.
- run_o  out  1  high in RUN and LAP.
- freeze_o  out  1  high in LAP; display holds last value while counter continues.
- state_o  out  2  current state encoding.

## Operation
- Input path per button: 2-flop synchronizer → debouncer → falling-edge detector. Debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples. Press event = debounced 1→0, one cycle. Release is ignored; a held button gives one event.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- IDLE: start → RUN; clear → clear_o pulse, stay IDLE; lap ignored.
- RUN: start → PAUSE; lap → LAP; clear → clear_o, IDLE.
- LAP: lap → RUN (freeze released); start → PAUSE (freeze released); clear → clear_o, IDLE.
- PAUSE: start → RUN; clear → clear_o, IDLE; lap ignored.
- Simultaneous events in one cycle: clear > start > lap. Only the highest-priority event acts; the rest are dropped.
- Prescaler, width $clog2(DIV):
  - Increments only while run_o = 1.
  - tick_o is high in the cycle where the count equals DIV−1; the count wraps to 0 on the same edge.
  - Holds its value in PAUSE, so a resume keeps the partial period.
  - Forced to 0 on entry to IDLE and on any clear_o.
- Reset asserted (asynchronous):
  - state IDLE; tick_o, clear_o, run_o, freeze_o, state_o all 0; prescaler 0.
  - Synchronizer and debounced levels set to 1 (released).
  - A button held low through reset release yields one press event once debounced.
- Reset asserted mid-operation aborts everything immediately. No clear_o is generated; the counter datapath shares the same reset.

## Timing
- Raw press edge to internal press pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge detect) cycles.
- Press pulse in cycle N → state_o, run_o, freeze_o updated and clear_o high in cycle N+1. All outputs are registered.
- Entering RUN from IDLE or PAUSE at cycle M (prescaler p) → first tick_o in cycle M + (DIV−1−p). From IDLE, p = 0, so the first tick is the DIV-th running cycle.
- tick_o never asserts in the cycle run_o falls or while run_o = 0.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.

## Structure
- Shared package stopwatch_pkg:
  - state enum (IDLE/RUN/PAUSE/LAP, 2-bit);
  - button index constants BTN_START=3, BTN_LAP=2, BTN_CLEAR=1, BTN_RSVD=0.
  - Used by the stopwatch top and its bench.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES): one raw active-low input; synchronizer, stability counter, press-pulse output. Instantiated 3 times (bit 0 is left unconnected).
- stopwatch_ctrl holds the FSM, priority logic and prescaler.

## Test plan
All scenarios use CLK_HZ=100, TICK_HZ=10 (DIV=10), DEBOUNCE_CYCLES=4.
- Reset: drive reset low 3 cycles, release. All outputs 0 and state_o=0. Assert reset mid-RUN: run_o and state_o drop to 0 immediately, with no clock edge needed.
- Start: button_i[3] low 12 cycles from IDLE. state_o=1 and run_o=1 exactly 8 cycles after the raw edge. tick_o pulses on running cycles 10, 20, 30; exactly one press is registered.
- Glitch: button_i[3] low 2 cycles in IDLE. No state change and no tick.
- Pause/resume: pause 7 running cycles into a tick period, wait 50 cycles, resume. No tick_o while paused; the next tick comes on the 3rd running cycle after run_o rises again.
- Lap: lap press in RUN → state_o=3, freeze_o=1, ticks continue every 10 cycles. Second lap press → state_o=1, freeze_o=0.
- Priority: start and clear released-to-pressed in the same cycle while RUN. Exactly one clear_o pulse, state_o=0, prescaler 0, no further tick_o.
